// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, cause and vector definitions for the pipeline sequencer
package mips_ctrl_pkg;

  // Sequencer states; encoding is fixed so the state is easy to recognise on a waveform
  typedef enum logic [1:0] {
    RUN          = 2'd0,
    MEM_WAIT     = 2'd1,
    EXC_DRAIN    = 2'd2,
    EXC_REDIRECT = 2'd3
  } ctrl_state_t;

  localparam logic [1:0]  CAUSE_NONE  = 2'd0;
  localparam logic [1:0]  CAUSE_ID    = 2'd1;
  localparam logic [1:0]  CAUSE_MEMTO = 2'd2;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

  // Width of the shared wait/drain counter; comfortably covers both the timeout and drain lengths
  localparam int          CTRL_CNT_W = 16;

endpackage

// File: rtl/ctrl_sat_counter.sv
// rtl/ctrl_sat_counter.sv - saturating up-counter with enable and synchronous clear
module ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Clear has priority; counting stops at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_pipeline_ctrl.sv
// rtl/hazard_pipeline_ctrl.sv - load-use, branch-flush, memory-freeze and exception sequencer
module hazard_pipeline_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int          EXC_DRAIN_CYCLES = 2,
  parameter int          MEM_TIMEOUT      = 16,
  parameter logic [31:0] EXC_VECTOR       = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegisterRt,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        ID_UsesRt,
  input  logic        BranchTaken,
  input  logic        Exception,
  input  logic        MemBusy,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        PipeFreeze,
  output logic        ExcRedirect,
  output logic [31:0] ExcPC,
  output logic [1:0]  ExcCause,
  output logic [15:0] StallCount
);

  localparam logic [CTRL_CNT_W-1:0] DRAIN_LOAD = CTRL_CNT_W'(EXC_DRAIN_CYCLES - 1);
  localparam logic [CTRL_CNT_W-1:0] TIMEOUT_LAST = CTRL_CNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t           r_state;
  ctrl_state_t           w_state_nxt;
  logic [CTRL_CNT_W-1:0] r_cnt;
  logic [CTRL_CNT_W-1:0] w_cnt_nxt;
  logic [1:0]            r_cause;
  logic [1:0]            w_cause_nxt;
  logic                  w_load_use;
  logic                  w_stall_en;

  // A load in EX whose destination feeds the ID instruction; $zero never creates a dependency
  assign w_load_use = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                      ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                       (ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

  // State, wait/drain counter and latched exception cause
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  // Next state and pipeline control outputs from the current state and hazard inputs
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cause_nxt  = r_cause;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    PipeFreeze   = 1'b0;
    ExcRedirect  = 1'b0;

    if (rst) begin
      // Hold the front end and inject bubbles until reset is released
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      w_state_nxt  = RUN;
    end else begin
      unique case (r_state)
        RUN: begin
          if (Exception) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            PCWrite      = 1'b0;
            w_state_nxt  = EXC_DRAIN;
            w_cnt_nxt    = DRAIN_LOAD;
            w_cause_nxt  = CAUSE_ID;
          end else if (MemBusy && !MemReady) begin
            // Same-cycle ready is a zero-wait access and does not freeze
            PipeFreeze  = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            w_state_nxt = MEM_WAIT;
            w_cnt_nxt   = '0;
          end else if (w_load_use) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end else if (BranchTaken) begin
            IF_ID_Flush = 1'b1;
          end
        end

        MEM_WAIT: begin
          // ID-stage events are ignored; the frozen instruction re-presents them in RUN
          PipeFreeze  = 1'b1;
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          w_cnt_nxt   = r_cnt + 1'b1;
          if (MemReady) begin
            w_state_nxt = RUN;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_state_nxt = EXC_DRAIN;
            w_cause_nxt = CAUSE_MEMTO;
            w_cnt_nxt   = DRAIN_LOAD;
          end
        end

        EXC_DRAIN: begin
          // Older instructions retire while nothing new enters the pipe
          PCWrite      = 1'b0;
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
          if (r_cnt == '0) begin
            w_state_nxt = EXC_REDIRECT;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end

        EXC_REDIRECT: begin
          ExcRedirect  = 1'b1;
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
          w_state_nxt  = RUN;
        end

        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  // Stall cycles are counted only outside reset
  assign w_stall_en = !rst && !PCWrite;

  ctrl_sat_counter #(
    .W(16)
  ) u_stall_cnt (
    .clk     (clk),
    .i_clr   (rst),
    .i_en    (w_stall_en),
    .o_count (StallCount)
  );

  assign ExcPC    = EXC_VECTOR;
  assign ExcCause = r_cause;

endmodule

// File: tb/tb_hazard_pipeline_ctrl.sv
// tb/tb_hazard_pipeline_ctrl.sv - directed self-checking bench for hazard_pipeline_ctrl
module tb_hazard_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_RegisterRt;
  logic [4:0]  IF_ID_RegisterRs;
  logic [4:0]  IF_ID_RegisterRt;
  logic        ID_UsesRt;
  logic        BranchTaken;
  logic        Exception;
  logic        MemBusy;
  logic        MemReady;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Bubble;
  logic        PipeFreeze;
  logic        ExcRedirect;
  logic [31:0] ExcPC;
  logic [1:0]  ExcCause;
  logic [15:0] StallCount;

  int checks = 0;
  int errors = 0;

  // Output pattern order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, PipeFreeze, ExcRedirect}
  localparam logic [5:0] P_RESET  = 6'b001100;
  localparam logic [5:0] P_RUN    = 6'b110000;
  localparam logic [5:0] P_LDUSE  = 6'b000100;
  localparam logic [5:0] P_BRANCH = 6'b111000;
  localparam logic [5:0] P_FREEZE = 6'b000010;
  localparam logic [5:0] P_EXC    = 6'b011100;
  localparam logic [5:0] P_REDIR  = 6'b111101;

  hazard_pipeline_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_RegisterRt (ID_EX_RegisterRt),
    .IF_ID_RegisterRs (IF_ID_RegisterRs),
    .IF_ID_RegisterRt (IF_ID_RegisterRt),
    .ID_UsesRt        (ID_UsesRt),
    .BranchTaken      (BranchTaken),
    .Exception        (Exception),
    .MemBusy          (MemBusy),
    .MemReady         (MemReady),
    .PCWrite          (PCWrite),
    .IF_ID_Write      (IF_ID_Write),
    .IF_ID_Flush      (IF_ID_Flush),
    .ID_EX_Bubble     (ID_EX_Bubble),
    .PipeFreeze       (PipeFreeze),
    .ExcRedirect      (ExcRedirect),
    .ExcPC            (ExcPC),
    .ExcCause         (ExcCause),
    .StallCount       (StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, PipeFreeze, ExcRedirect},
        {26'd0, exp});
  endtask

  // Move to the next negedge (inputs are then driven by the caller, checks come #1 later)
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ID_EX_MemRead    = 1'b0;
    ID_EX_RegisterRt = 5'd0;
    IF_ID_RegisterRs = 5'd0;
    IF_ID_RegisterRt = 5'd0;
    ID_UsesRt        = 1'b0;
    BranchTaken      = 1'b0;
    Exception        = 1'b0;
    MemBusy          = 1'b0;
    MemReady         = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Reset state
    next_cycle(); next_cycle(); #1;
    chk_out("reset_outputs", P_RESET);
    chk("reset_cause", {30'd0, ExcCause}, 32'd0);
    chk("reset_stall", {16'd0, StallCount}, 32'd0);
    chk("exc_pc", ExcPC, 32'h8000_0180);

    next_cycle(); rst = 1'b0; #1;
    chk_out("run_default", P_RUN);

    // T1 load-use on rs, then $zero destination, then rt path with and without ID_UsesRt
    next_cycle(); ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd5; IF_ID_RegisterRs = 5'd5; #1;
    chk_out("t1_lduse_rs", P_LDUSE);
    next_cycle(); ID_EX_RegisterRt = 5'd0; IF_ID_RegisterRs = 5'd0; #1;
    chk_out("t1_rt_zero", P_RUN);
    next_cycle(); ID_EX_RegisterRt = 5'd5; IF_ID_RegisterRs = 5'd3; IF_ID_RegisterRt = 5'd5;
    ID_UsesRt = 1'b1; #1;
    chk_out("t1_lduse_rt", P_LDUSE);
    next_cycle(); ID_UsesRt = 1'b0; #1;
    chk_out("t1_rt_unused", P_RUN);
    chk("t1_stall_count", {16'd0, StallCount}, 32'd2);

    // T2 load-use outranks a taken branch
    next_cycle(); IF_ID_RegisterRs = 5'd5; BranchTaken = 1'b1; #1;
    chk_out("t2_lduse_over_branch", P_LDUSE);
    next_cycle(); ID_EX_MemRead = 1'b0; #1;
    chk_out("t2_branch_flush", P_BRANCH);

    // T3 freeze for t0..t0+3, Exception ignored while waiting
    next_cycle(); clear_inputs(); MemBusy = 1'b1; #1;
    chk_out("t3_t0_freeze", P_FREEZE);
    chk("t3_stall_before", {16'd0, StallCount}, 32'd3);
    next_cycle(); Exception = 1'b1; BranchTaken = 1'b1; #1;
    chk_out("t3_t1_freeze_ign_exc", P_FREEZE);
    next_cycle(); Exception = 1'b0; BranchTaken = 1'b0; #1;
    chk_out("t3_t2_freeze", P_FREEZE);
    next_cycle(); MemReady = 1'b1; #1;
    chk_out("t3_t3_ready_frozen", P_FREEZE);
    next_cycle(); clear_inputs(); #1;
    chk_out("t3_t4_run", P_RUN);
    chk("t3_stall_count", {16'd0, StallCount}, 32'd7);
    chk("t3_cause_unchanged", {30'd0, ExcCause}, 32'd0);

    // Zero-wait access: busy and ready together never freeze
    next_cycle(); MemBusy = 1'b1; MemReady = 1'b1; #1;
    chk_out("zero_wait", P_RUN);
    next_cycle(); clear_inputs(); #1;
    chk_out("zero_wait_after", P_RUN);
    chk("zero_wait_stall", {16'd0, StallCount}, 32'd7);

    // T4 memory timeout after 16 MEM_WAIT cycles
    next_cycle(); MemBusy = 1'b1; #1;
    chk_out("t4_enter", P_FREEZE);
    for (int i = 0; i < 16; i++) begin
      next_cycle(); #1;
      chk_out($sformatf("t4_wait_%0d", i), P_FREEZE);
    end
    next_cycle(); #1;
    chk_out("t4_drain1", P_EXC);
    chk("t4_cause", {30'd0, ExcCause}, 32'd2);
    next_cycle(); #1;
    chk_out("t4_drain2", P_EXC);
    next_cycle(); MemBusy = 1'b0; #1;
    chk_out("t4_redirect", P_REDIR);
    chk("t4_exc_pc", ExcPC, 32'h8000_0180);
    next_cycle(); #1;
    chk_out("t4_back_run", P_RUN);
    chk("t4_stall_count", {16'd0, StallCount}, 32'd26);
    chk("t4_cause_held", {30'd0, ExcCause}, 32'd2);

    // T5 ID exception: three flush+bubble cycles, redirect on the fourth
    next_cycle(); Exception = 1'b1; #1;
    chk_out("t5_exc_run", P_EXC);
    next_cycle(); Exception = 1'b0; BranchTaken = 1'b1; #1;
    chk_out("t5_drain1", P_EXC);
    chk("t5_cause", {30'd0, ExcCause}, 32'd1);
    next_cycle(); #1;
    chk_out("t5_drain2", P_EXC);
    next_cycle(); BranchTaken = 1'b0; #1;
    chk_out("t5_redirect", P_REDIR);
    next_cycle(); #1;
    chk_out("t5_back_run", P_RUN);
    chk("t5_stall_count", {16'd0, StallCount}, 32'd29);

    // T6 reset during the second drain cycle aborts the exception
    next_cycle(); Exception = 1'b1; #1;
    chk_out("t6_exc_run", P_EXC);
    next_cycle(); Exception = 1'b0; #1;
    chk_out("t6_drain1", P_EXC);
    next_cycle(); rst = 1'b1; #1;
    chk_out("t6_rst_outputs", P_RESET);
    next_cycle(); rst = 1'b0; #1;
    chk_out("t6_run_after_rst", P_RUN);
    chk("t6_cause_cleared", {30'd0, ExcCause}, 32'd0);
    chk("t6_stall_cleared", {16'd0, StallCount}, 32'd0);
    next_cycle(); #1;
    chk_out("t6_no_redirect", P_RUN);

    // Saturation: hold a load-use hazard so every cycle stalls
    next_cycle(); ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd7; IF_ID_RegisterRs = 5'd7; #1;
    chk_out("sat_lduse", P_LDUSE);
    repeat (65534) next_cycle();
    #1;
    chk("sat_fffe", {16'd0, StallCount}, 32'h0000_FFFE);
    next_cycle(); #1;
    chk("sat_ffff", {16'd0, StallCount}, 32'h0000_FFFF);
    repeat (5) next_cycle();
    #1;
    chk("sat_hold", {16'd0, StallCount}, 32'h0000_FFFF);
    next_cycle(); clear_inputs(); #1;
    chk_out("sat_release", P_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
